// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined shift unit.
// Optional rotate support is selected by SHIFT_UNIT_ROTATE_EN in the users of this package.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } shift_op_t;

  localparam int WORD_W = 32;

  // Widest datapath bitrev can serve; callers pass the live width in n.
  localparam int BITREV_MAX = 256;

  function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] d,
                                                   input int unsigned n);
    logic [BITREV_MAX-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < BITREV_MAX; i++) begin
      if (i < n) r[i] = d[n-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_level_group.sv
// Combinational right-shift mux levels [FIRST_LEVEL, FIRST_LEVEL+NUM_LEVELS) for one pipe stage.
// With SHIFT_UNIT_ROTATE_EN defined, i_rot makes each level refill from the wrapped-out bits.
module shift_level_group #(
  parameter int N           = 64,
  parameter int FIRST_LEVEL = 0,
  parameter int NUM_LEVELS  = 1,
  localparam int K          = $clog2(N)
) (
  input  logic [N-1:0] i_data,
  input  logic [K-1:0] i_shamt,
  input  logic         i_fill,
`ifdef SHIFT_UNIT_ROTATE_EN
  input  logic         i_rot,
`endif
  output logic [N-1:0] o_data
);

  always_comb begin
    logic [N-1:0] v;
    logic [N-1:0] ins;
    v   = i_data;
    ins = '0;
    for (int j = FIRST_LEVEL; j < FIRST_LEVEL + NUM_LEVELS; j++) begin
      ins = {N{i_fill}} & ~({N{1'b1}} >> (1 << j));
`ifdef SHIFT_UNIT_ROTATE_EN
      if (i_rot) ins = v << (N - (1 << j));
`endif
      if (i_shamt[j]) v = (v >> (1 << j)) | ins;
    end
    o_data = v;
  end

endmodule

// File: rtl/shift_unit_pipe.sv
// Elastic, pipelined SLL/SRL/SRA barrel shifter with RV64 word ops, tag passthrough and flush.
// Defining SHIFT_UNIT_ROTATE_EN turns op 11 into ROR; otherwise op 11 behaves as SRL.
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int N      = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  shift_op_t            op,
  input  logic                 word,
  input  logic [$clog2(N)-1:0] shamt,
  input  logic [N-1:0]         data_in,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         data_out,
  output logic [TAG_W-1:0]     tag_out
);

  localparam int K = $clog2(N);
  localparam int L = (K + STAGES - 1) / STAGES;

  generate
    if (STAGES < 1 || STAGES > K) begin : g_bad_stages
      $error("shift_unit_pipe: STAGES must lie in 1..$clog2(N)");
    end
    if (N < 8 || (N & (N - 1)) != 0 || N > BITREV_MAX) begin : g_bad_width
      $error("shift_unit_pipe: N must be a power of two between 8 and BITREV_MAX");
    end
  endgenerate

  logic [STAGES-1:0] r_valid;
  logic [N-1:0]      r_data  [STAGES];
  shift_op_t         r_op    [STAGES];
  logic              r_word  [STAGES];
  logic [K-1:0]      r_shamt [STAGES];
  logic [TAG_W-1:0]  r_tag   [STAGES];

  logic [N-1:0]      w_stg_data  [STAGES];
  shift_op_t         w_stg_op    [STAGES];
  logic              w_stg_word  [STAGES];
  logic [K-1:0]      w_stg_shamt [STAGES];
  logic [TAG_W-1:0]  w_stg_tag   [STAGES];
  logic              w_stg_vin   [STAGES];
  logic              w_stg_fill  [STAGES];
  logic [N-1:0]      w_lvl_out   [STAGES];
  logic [N-1:0]      w_stg_res   [STAGES];
  logic [STAGES-1:0] w_ready;

  shift_op_t    w_op_eff;
  logic         w_word_eff;
  logic         w_accept;
  logic [K-1:0] w_shamt_eff;
  logic [N-1:0] w_word_pre;
  logic [N-1:0] w_pre;
  logic [N-1:0] w_last_lvl;
  logic [N-1:0] w_post;

  // A stage can take new data unless it and every stage after it is full while the sink stalls.
  generate
    for (genvar s = 0; s < STAGES; s++) begin : g_ready
      assign w_ready[s] = ~(&r_valid[STAGES-1:s]) | out_ready;
    end
  endgenerate

  assign in_ready = !flush && w_ready[0];
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_op_eff = op;
`ifndef SHIFT_UNIT_ROTATE_EN
    if (op == SH_ROR) w_op_eff = SH_SRL;
`endif
  end

  assign w_word_eff = (N == 64) && word;

  always_comb begin
    w_shamt_eff = shamt;
    if (w_word_eff) w_shamt_eff[K-1] = 1'b0;
  end

  generate
    if (N == 64) begin : g_word
      always_comb begin
        w_word_pre = data_in;
        if (w_word_eff) begin
          case (w_op_eff)
            SH_SRL:  w_word_pre[N-1:WORD_W] = '0;
            SH_SRA:  w_word_pre[N-1:WORD_W] = {(N-WORD_W){data_in[WORD_W-1]}};
`ifdef SHIFT_UNIT_ROTATE_EN
            // Doubling the low word lets a full-width rotate act as a 32-bit rotate.
            SH_ROR:  w_word_pre[N-1:WORD_W] = data_in[WORD_W-1:0];
`endif
            default: w_word_pre = data_in;
          endcase
        end
      end

      always_comb begin
        w_post = w_last_lvl;
        if (w_stg_word[STAGES-1]) w_post[N-1:WORD_W] = {(N-WORD_W){w_last_lvl[WORD_W-1]}};
      end
    end else begin : g_no_word
      assign w_word_pre = data_in;
      assign w_post     = w_last_lvl;
    end
  endgenerate

  // Left shifts reuse the right-shift core by mirroring the operand and the result.
  assign w_pre = (w_op_eff == SH_SLL) ? N'(bitrev(BITREV_MAX'(w_word_pre), N)) : w_word_pre;

  assign w_last_lvl = (w_stg_op[STAGES-1] == SH_SLL)
                    ? N'(bitrev(BITREV_MAX'(w_lvl_out[STAGES-1]), N))
                    : w_lvl_out[STAGES-1];

  generate
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int FIRST = s * L;
      localparam int LAST  = ((s + 1) * L < K) ? (s + 1) * L : K;
      localparam int NUM   = (LAST > FIRST) ? LAST - FIRST : 0;

      if (s == 0) begin : g_src_in
        assign w_stg_data[s]  = w_pre;
        assign w_stg_op[s]    = w_op_eff;
        assign w_stg_word[s]  = w_word_eff;
        assign w_stg_shamt[s] = w_shamt_eff;
        assign w_stg_tag[s]   = tag_in;
        assign w_stg_vin[s]   = w_accept;
      end else begin : g_src_reg
        assign w_stg_data[s]  = r_data[s-1];
        assign w_stg_op[s]    = r_op[s-1];
        assign w_stg_word[s]  = r_word[s-1];
        assign w_stg_shamt[s] = r_shamt[s-1];
        assign w_stg_tag[s]   = r_tag[s-1];
        assign w_stg_vin[s]   = r_valid[s-1];
      end

      // The MSB survives every arithmetic level, so it stays a valid fill source downstream.
      assign w_stg_fill[s] = (w_stg_op[s] == SH_SRA) && w_stg_data[s][N-1];

      shift_level_group #(
        .N          (N),
        .FIRST_LEVEL(FIRST),
        .NUM_LEVELS (NUM)
      ) u_levels (
        .i_data (w_stg_data[s]),
        .i_shamt(w_stg_shamt[s]),
        .i_fill (w_stg_fill[s]),
`ifdef SHIFT_UNIT_ROTATE_EN
        .i_rot  (w_stg_op[s] == SH_ROR),
`endif
        .o_data (w_lvl_out[s])
      );

      if (s == STAGES - 1) begin : g_res_last
        assign w_stg_res[s] = w_post;
      end else begin : g_res_mid
        assign w_stg_res[s] = w_lvl_out[s];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        r_valid[s] <= 1'b0;
        r_data[s]  <= '0;
        r_op[s]    <= SH_SLL;
        r_word[s]  <= 1'b0;
        r_shamt[s] <= '0;
        r_tag[s]   <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (flush) begin
          r_valid[s] <= 1'b0;
        end else if (w_ready[s]) begin
          r_valid[s] <= w_stg_vin[s];
          if (w_stg_vin[s]) begin
            r_data[s]  <= w_stg_res[s];
            r_op[s]    <= w_stg_op[s];
            r_word[s]  <= w_stg_word[s];
            r_shamt[s] <= w_stg_shamt[s];
            r_tag[s]   <= w_stg_tag[s];
          end
        end
      end
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign data_out  = r_data[STAGES-1];
  assign tag_out   = r_tag[STAGES-1];

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Self-checking bench for shift_unit_pipe: queue-based reference model plus directed cases.
// Build with SHIFT_UNIT_ROTATE_EN defined to also exercise ROR.
module tb_shift_unit_pipe;
  import shift_pkg::*;

  localparam int N      = 64;
  localparam int STAGES = 2;
  localparam int TAG_W  = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  shift_op_t        op;
  logic             word;
  logic [5:0]       shamt;
  logic [N-1:0]     data_in;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     data_out;
  logic [TAG_W-1:0] tag_out;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [63:0]      d;
    logic [TAG_W-1:0] t;
    int               ready_at;
  } exp_t;

  exp_t             q[$];
  logic [TAG_W-1:0] got_tags[$];

  shift_unit_pipe #(.N(N), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .word(word), .shamt(shamt), .data_in(data_in), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .tag_out(tag_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain shift operators on the architectural word sizes.
  function automatic logic [63:0] model(input logic [1:0] o, input logic w,
                                        input logic [5:0] sh, input logic [63:0] d);
    logic [31:0] r32;
    logic [63:0] r64;
    int          s;
    if (w) begin
      s = int'(sh[4:0]);
      case (o)
        2'd0:    r32 = d[31:0] << s;
        2'd2:    r32 = 32'($signed(d[31:0]) >>> s);
`ifdef SHIFT_UNIT_ROTATE_EN
        2'd3:    r32 = (d[31:0] >> s) | (d[31:0] << (32 - s));
`endif
        default: r32 = d[31:0] >> s;
      endcase
      return {{32{r32[31]}}, r32};
    end
    s = int'(sh);
    case (o)
      2'd0:    r64 = d << s;
      2'd2:    r64 = 64'($signed(d) >>> s);
`ifdef SHIFT_UNIT_ROTATE_EN
      2'd3:    r64 = (d >> s) | (d << (64 - s));
`endif
      default: r64 = d >> s;
    endcase
    return r64;
  endfunction

  // Every accepted op reaches the output exactly STAGES edges later unless the sink stalls the head.
  always @(negedge clk) begin
    logic exp_ov;
    if (rst) begin
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_data_out", data_out, 64'h0);
      q.delete();
    end else begin
      check("in_ready", in_ready, !flush && (q.size() < STAGES || out_ready));
      exp_ov = (q.size() > 0) && (cyc >= q[0].ready_at);
      check("out_valid", out_valid, exp_ov);
      if (out_valid && exp_ov) begin
        check("data_out", data_out, q[0].d);
        check("tag_out", tag_out, q[0].t);
      end
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready && exp_ov) begin
          got_tags.push_back(tag_out);
          void'(q.pop_front());
        end
        if (in_valid && in_ready)
          q.push_back('{model(op, word, shamt, data_in), tag_in, cyc + STAGES});
      end
    end
  end

  task automatic set_in(input shift_op_t o, input logic w, input logic [5:0] sh,
                        input logic [63:0] d, input logic [TAG_W-1:0] t);
    op = o; word = w; shamt = sh; data_in = d; tag_in = t;
  endtask

  // Called just after a rising edge with an empty pipe and out_ready high.
  task automatic issue_wait(input string name, input shift_op_t o, input logic w,
                            input logic [5:0] sh, input logic [63:0] d, input logic [63:0] exp);
    int lat;
    check({name, "_model"}, model(o, w, sh, d), exp);
    set_in(o, w, sh, d, 5'd17);
    in_valid = 1'b1;
    @(negedge clk);
    check({name, "_accept"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        check(name, data_out, exp);
      end
    end
    check({name, "_latency"}, lat, STAGES);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    int cnt;
    logic [TAG_W-1:0] tk;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_in(SH_SLL, 1'b0, 6'd0, 64'h0, '0);
    #2;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_tag_out", tag_out, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    issue_wait("srl_63", SH_SRL, 1'b0, 6'd63, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001);
    issue_wait("sra_4", SH_SRA, 1'b0, 6'd4, 64'hF000_0000_0000_0000, 64'hFF00_0000_0000_0000);
    issue_wait("srl_4", SH_SRL, 1'b0, 6'd4, 64'hF000_0000_0000_0000, 64'h0F00_0000_0000_0000);
    issue_wait("sllw_1", SH_SLL, 1'b1, 6'd1, 64'h1234_5678_4000_0001, 64'hFFFF_FFFF_8000_0002);
    // shamt[5] is ignored for word ops: effective shift of 4.
    issue_wait("sraw_24", SH_SRA, 1'b1, 6'h24, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_F800_0000);
    issue_wait("sll_0", SH_SLL, 1'b0, 6'd0, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567);
    issue_wait("srlw_0", SH_SRL, 1'b1, 6'd0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000);
    issue_wait("sll_63", SH_SLL, 1'b0, 6'd63, 64'h0000_0000_0000_0003, 64'h8000_0000_0000_0000);
`ifdef SHIFT_UNIT_ROTATE_EN
    issue_wait("ror_1", SH_ROR, 1'b0, 6'd1, 64'h1, 64'h8000_0000_0000_0000);
    issue_wait("rorw_1", SH_ROR, 1'b1, 6'd1, 64'h1, 64'hFFFF_FFFF_8000_0000);
`else
    issue_wait("op3_as_srl", SH_ROR, 1'b0, 6'd1, 64'h1, 64'h0);
`endif

    // Backpressure: three back-to-back requests into a stalled two-deep pipe.
    got_tags.delete();
    out_ready = 1'b0;
    acc = 0;
    tk  = 5'd1;
    for (int i = 0; i < 4; i++) begin
      set_in(SH_SRL, 1'b0, 6'(tk), {32'hDEAD_BEEF, 27'h0, tk}, tk);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin acc++; tk++; end
      @(posedge clk); #1;
    end
    check("bp_accepted", acc, 2);
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = (tk <= 5'd3);
      set_in(SH_SRL, 1'b0, 6'(tk), {32'hDEAD_BEEF, 27'h0, tk}, tk);
      @(negedge clk);
      if (in_valid && in_ready) tk++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_count", got_tags.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < got_tags.size()) check("bp_order", got_tags[i], 5'(i + 1));

    // Flush with two ops in flight and a same-cycle request.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_in(SH_SLL, 1'b0, 6'd3, 64'h55, 5'(i + 4));
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    set_in(SH_SLL, 1'b0, 6'd1, 64'h77, 5'd7);
    @(negedge clk);
    check("flush_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", out_valid, 1'b0);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("flush_no_result", cnt, 0);
    @(posedge clk); #1;

    // Asynchronous reset while the output is stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_in(SH_SRL, 1'b0, 6'd4, 64'hFFFF_0000_1234_5678, 5'(i + 9));
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stall_out_valid", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_data_out", data_out, 64'h0);
    check("midrst_tag_out", tag_out, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;

    // Random traffic, stalls and occasional flushes against the queue model.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      op        = shift_op_t'($urandom_range(0, 3));
      word      = $urandom_range(0, 1);
      case ($urandom_range(0, 7))
        0:       shamt = 6'd0;
        1:       shamt = 6'd63;
        2:       shamt = 6'd31;
        default: shamt = 6'($urandom_range(0, 63));
      endcase
      data_in = {$urandom, $urandom};
      tag_in  = 5'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
